// File: rtl/cbd_sampler.sv
// cbd_sampler: multi-lane centered-binomial sampler. Each lane owns a Galois LFSR and
// yields one signed coefficient per block; blocks stream out over valid/ready in bursts.
module cbd_sampler #(
  parameter int                ETA       = 2,
  parameter int                LANES     = 4,
  parameter int                COEF_W    = 4,
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003,
  parameter int                CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seed_load,
  input  logic [LFSR_W-1:0]       seed,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_blocks,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*COEF_W-1:0] out_coef,
  output logic                    rnd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    load_s;
  logic                    last_hs_s;
  logic                    zero_start_s;
  logic [LFSR_W-1:0]       lfsr_r      [LANES];
  logic [LFSR_W-1:0]       lfsr_next_s [LANES];
  logic [LFSR_W-1:0]       lfsr_seed_s [LANES];
  logic [LANES*COEF_W-1:0] coef_s;
  logic [LANES*COEF_W-1:0] out_coef_r;
  logic [CNT_W-1:0]        blocks_left_r;
  logic                    out_valid_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    rnd_r;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] r;
    if (s[0]) begin
      r = (s >> 1) ^ LFSR_TAPS;
    end else begin
      r = s >> 1;
    end
    return r;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_block_adv(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] t;
    t = s;
    for (int j = 0; j < 2*ETA; j++) begin
      t = lfsr_step(t);
    end
    return t;
  endfunction

  // First ETA emitted bits add, the next ETA subtract; modular arithmetic gives two's complement.
  function automatic logic [COEF_W-1:0] cbd_coef(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] t;
    logic [COEF_W-1:0] acc;
    t   = s;
    acc = {COEF_W{1'b0}};
    for (int j = 0; j < 2*ETA; j++) begin
      if (j < ETA) begin
        acc = acc + COEF_W'(t[0]);
      end else begin
        acc = acc - COEF_W'(t[0]);
      end
      t = lfsr_step(t);
    end
    return acc;
  endfunction

  // An all-zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] lane_seed(input logic [LFSR_W-1:0] sd, input int k);
    logic [63:0]       prod;
    logic [LFSR_W-1:0] v;
    prod = 64'h0000_0000_9E37_79B9 * 64'(k);
    v    = sd ^ LFSR_W'(prod);
    return (v == {LFSR_W{1'b0}}) ? LFSR_W'(1'b1) : v;
  endfunction

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lfsr_next_s[k]               = lfsr_block_adv(lfsr_r[k]);
    assign lfsr_seed_s[k]               = lane_seed(seed, k);
    assign coef_s[k*COEF_W +: COEF_W]   = cbd_coef(lfsr_r[k]);
  end

  // Next-state and load/done decode; seed_load overrides everything.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    last_hs_s    = 1'b0;
    zero_start_s = 1'b0;
    if (seed_load) begin
      state_next_s = READY;
    end else begin
      case (state_r)
        IDLE: begin
          state_next_s = IDLE;
        end
        READY: begin
          if (start && (num_blocks == {CNT_W{1'b0}})) begin
            zero_start_s = 1'b1;
          end else if (start) begin
            load_s       = 1'b1;
            state_next_s = RUN;
          end else begin
            state_next_s = READY;
          end
        end
        RUN: begin
          if (out_valid_r && out_ready && (blocks_left_r == {CNT_W{1'b0}})) begin
            last_hs_s    = 1'b1;
            state_next_s = READY;
          end else if ((blocks_left_r != {CNT_W{1'b0}}) && (!out_valid_r || out_ready)) begin
            load_s = 1'b1;
          end else begin
            load_s = 1'b0;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // LFSR lanes, output block register and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < LANES; k++) begin
        lfsr_r[k] <= {LFSR_W{1'b0}};
      end
      out_coef_r    <= {(LANES*COEF_W){1'b0}};
      out_valid_r   <= 1'b0;
      blocks_left_r <= {CNT_W{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      rnd_r         <= 1'b0;
    end else if (seed_load) begin
      for (int k = 0; k < LANES; k++) begin
        lfsr_r[k] <= lfsr_seed_s[k];
      end
      out_valid_r   <= 1'b0;
      blocks_left_r <= {CNT_W{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      rnd_r         <= lfsr_seed_s[0][0];
    end else begin
      done_r <= last_hs_s | zero_start_s;
      busy_r <= (state_next_s == RUN);
      if (load_s) begin
        for (int k = 0; k < LANES; k++) begin
          lfsr_r[k] <= lfsr_next_s[k];
        end
        out_coef_r  <= coef_s;
        out_valid_r <= 1'b1;
        rnd_r       <= lfsr_next_s[0][0];
        if (state_r == READY) begin
          blocks_left_r <= num_blocks - CNT_W'(1'b1);
        end else begin
          blocks_left_r <= blocks_left_r - CNT_W'(1'b1);
        end
      end else if (last_hs_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign out_valid = out_valid_r;
  assign out_coef  = out_coef_r;
  assign rnd       = rnd_r;

endmodule
